// File: rtl/receptor_display.sv
// receptor_display
//   Device end of the 4-wire display link. Rebuilds command/data bytes from
//   io_sclk/io_sdin/io_cs/io_dc, tracks the column/page write window and
//   drives a 1024-byte framebuffer write port.
// Ports:
//   clk, rst_n             system clock (>= 4x io_sclk), async active-low reset
//   io_sclk, io_sdin       SPI mode 0 clock and MSB-first data
//   io_cs, io_dc           chip select (active low), 0=command / 1=data
//   io_reset               display reset, active low (synchronous effect)
//   wr_en/wr_addr/wr_data  framebuffer write strobe, {page,col}, byte
//   cmd_valid/cmd_byte     strobe and value for every command-channel byte
//   display_on             set by 0xAF, cleared by 0xAE
//   frame_done             pulses with the write to the last window cell
module receptor_display #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       io_sclk,
  input  logic       io_sdin,
  input  logic       io_cs,
  input  logic       io_dc,
  input  logic       io_reset,
  output logic       wr_en,
  output logic [9:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       cmd_valid,
  output logic [7:0] cmd_byte,
  output logic       display_on,
  output logic       frame_done
);

  typedef enum logic [2:0] {IDLE, COL_S, COL_E, PAGE_S, PAGE_E} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, sdin_sync, cs_sync, dc_sync, rst_sync;
  logic sclk_s, sdin_s, cs_s, dc_s, soft_rst, sclk_prev, rise;

  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] nxt;
  logic       byte_done, byte_dc;
  logic [7:0] byte_val;

  state_t     state_q, state_d;
  logic       ld_cs, ld_ce, ld_ps, ld_pe, disp_set, disp_clr;
  logic [6:0] col, col_start, col_end, pend_col;
  logic [2:0] page, page_start, page_end, pend_page;
  logic       at_col_end, at_page_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '0;
      sdin_sync <= '0;
      cs_sync   <= '1;
      dc_sync   <= '0;
      rst_sync  <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], io_sclk};
      sdin_sync <= {sdin_sync[SYNC_STAGES-2:0], io_sdin};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], io_cs};
      dc_sync   <= {dc_sync[SYNC_STAGES-2:0], io_dc};
      rst_sync  <= {rst_sync[SYNC_STAGES-2:0], io_reset};
    end
  end

  assign sclk_s   = sclk_sync[SYNC_STAGES-1];
  assign sdin_s   = sdin_sync[SYNC_STAGES-1];
  assign cs_s     = cs_sync[SYNC_STAGES-1];
  assign dc_s     = dc_sync[SYNC_STAGES-1];
  assign soft_rst = ~rst_sync[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_prev;
  assign nxt      = {shift, sdin_s};

  // Byte assembly: byte_done is a one-cycle pulse carrying the byte and its dc.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_prev <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
      byte_done <= 1'b0;
      byte_val  <= '0;
      byte_dc   <= 1'b0;
    end else if (soft_rst) begin
      sclk_prev <= sclk_s;
      bit_cnt   <= '0;
      shift     <= '0;
      byte_done <= 1'b0;
      byte_val  <= '0;
      byte_dc   <= 1'b0;
    end else begin
      sclk_prev <= sclk_s;
      byte_done <= 1'b0;
      if (cs_s) begin
        bit_cnt <= '0;
      end else if (rise) begin
        shift   <= nxt[6:0];
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          byte_done <= 1'b1;
          byte_val  <= nxt;
          byte_dc   <= dc_s;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        state_q <= IDLE;
    else if (soft_rst) state_q <= IDLE;
    else               state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ld_cs    = 1'b0;
    ld_ce    = 1'b0;
    ld_ps    = 1'b0;
    ld_pe    = 1'b0;
    disp_set = 1'b0;
    disp_clr = 1'b0;
    if (byte_done) begin
      if (byte_dc) begin
        state_d = IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (byte_val == 8'h21)      state_d = COL_S;
            else if (byte_val == 8'h22) state_d = PAGE_S;
            disp_set = (byte_val == 8'hAF);
            disp_clr = (byte_val == 8'hAE);
          end
          COL_S:  begin ld_cs = 1'b1; state_d = COL_E;  end
          COL_E:  begin ld_ce = 1'b1; state_d = IDLE;   end
          PAGE_S: begin ld_ps = 1'b1; state_d = PAGE_E; end
          PAGE_E: begin ld_pe = 1'b1; state_d = IDLE;   end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  assign at_col_end  = (col == col_end);
  assign at_page_end = (page == page_end);

  // Start values are staged in pend_* and committed together with the end
  // value, so an aborted argument sequence leaves the live window untouched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en <= 1'b0; wr_addr <= '0; wr_data <= '0; frame_done <= 1'b0;
      cmd_valid <= 1'b0; cmd_byte <= '0; display_on <= 1'b0;
      col <= '0; page <= '0; col_start <= '0; col_end <= '1;
      page_start <= '0; page_end <= '1; pend_col <= '0; pend_page <= '0;
    end else if (soft_rst) begin
      wr_en <= 1'b0; wr_addr <= '0; wr_data <= '0; frame_done <= 1'b0;
      cmd_valid <= 1'b0; cmd_byte <= '0; display_on <= 1'b0;
      col <= '0; page <= '0; col_start <= '0; col_end <= '1;
      page_start <= '0; page_end <= '1; pend_col <= '0; pend_page <= '0;
    end else begin
      wr_en      <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (byte_done && byte_dc) begin
        wr_en      <= 1'b1;
        wr_addr    <= {page, col};
        wr_data    <= byte_val;
        frame_done <= at_col_end && at_page_end;
        if (at_col_end) begin
          col  <= col_start;
          page <= at_page_end ? page_start : page + 3'd1;
        end else begin
          col <= col + 7'd1;
        end
      end
      if (byte_done && !byte_dc) begin
        cmd_valid <= 1'b1;
        cmd_byte  <= byte_val;
      end
      if (disp_set) display_on <= 1'b1;
      if (disp_clr) display_on <= 1'b0;
      if (ld_cs) pend_col <= byte_val[6:0];
      if (ld_ce) begin
        col_start <= pend_col;
        col_end   <= byte_val[6:0];
        col       <= pend_col;
      end
      if (ld_ps) pend_page <= byte_val[2:0];
      if (ld_pe) begin
        page_start <= pend_page;
        page_end   <= byte_val[2:0];
        page       <= pend_page;
      end
    end
  end

endmodule

// File: doc/receptor_display.md
# receptor_display

SPI display receiver: the device end of the 4-wire link driven by `controlador_display`. It rebuilds SSD1306-style command and data bytes from io_sclk/io_sdin/io_cs/io_dc and runs the column/page address FSM. Each data byte goes to a 1024-byte framebuffer write port. It is instantiated in the self-checking bench and in the loopback build, where the framebuffer contents are compared against `controlador_imagens` output.

## Interface
- SYNC_STAGES, 2, synchronizer depth for all io_* inputs (≥2)
- clk  in  1  system clock; must be ≥4× io_sclk frequency
- rst_n  in  1  asynchronous active-low reset
- io_sclk  in  1  SPI clock, mode 0 (idle low, sample on rising edge)
- io_sdin  in  1  serial data, MSB first
- io_cs  in  1  chip select, active low
- io_dc  in  1  0 = command byte, 1 = data byte
- io_reset  in  1  display reset, active low
- wr_en  out  1  one-cycle framebuffer write strobe
- wr_addr  out  10  write address = page*128 + column
- wr_data  out  8  byte to write
- cmd_valid  out  1  one-cycle strobe per command byte (dc=0)
- cmd_byte  out  8  received command byte
- display_on  out  1  1 after 0xAF, 0 after 0xAE
- frame_done  out  1  one-cycle pulse on write to the last cell of the window

## Operation
- All io_* pass through SYNC_STAGES flops. sclk rising edge is detected on the synchronized signal: current 1, previous 0.
- io_cs synchronized high: bit counter cleared, partial byte discarded. The address FSM and pointers are kept.
- On each detected rise with cs low: shift in sdin. On the 8th bit, also latch dc and complete the byte.
- Completed byte, dc=1: wr_en=1, wr_addr={page,col}, wr_data=byte. Then the pointer advances.
- Pointer advance:
  - col==col_end: col=col_start; then page=page_start if page==page_end, else page+1 (mod 8).
  - Otherwise col+1 (mod 128).
  - start>end windows therefore wrap through 127→0 (columns) or 7→0 (pages).
- frame_done pulses with the write made at col==col_end && page==page_end.
- Completed byte, dc=0: cmd_valid=1, cmd_byte=byte. Then the argument FSM runs:
  - IDLE: 0x21→COL_S; 0x22→PAGE_S; 0xAF sets display_on; 0xAE clears it; others ignored.
  - COL_S: col_start=byte[6:0]→COL_E.
  - COL_E: col_end=byte[6:0]; col=col_start→IDLE.
  - PAGE_S: page_start=byte[2:0]→PAGE_E.
  - PAGE_E: page_end=byte[2:0]; page=page_start→IDLE.
  - Argument bytes also raise cmd_valid.
- Data byte while in COL_S/COL_E/PAGE_S/PAGE_E: FSM returns to IDLE and the pending window is discarded. The byte is written at the current pointer.
- Synchronized io_reset low behaves like rst_n, applied synchronously. It holds all state in reset while low.

## Timing
- Reset values:
  - Outputs: wr_en=0, wr_addr=0, wr_data=0, cmd_valid=0, cmd_byte=0, display_on=0, frame_done=0.
  - Internal: col=0, page=0, col_start=0, col_end=127, page_start=0, page_end=7, FSM=IDLE, bit counter=0.
- Latency: the pin rise of the 8th sclk gives wr_en/cmd_valid exactly SYNC_STAGES+2 clk cycles later. All outputs are registered.
- Strobes last exactly 1 cycle. wr_addr/wr_data/cmd_byte hold until the next strobe.
- Pointer update is visible on the write after the strobe, never on the same one.
- Mid-byte rst_n/io_reset/cs-high: no strobe is produced for that byte.
- rst_n asserted mid-frame: outputs go to reset values immediately, without waiting for clk.

## Test plan
- Reset, then 1024 data bytes 0x00..0xFF repeating with default window:
  - wr_addr 0..1023 in order, wr_data matches the sent bytes.
  - frame_done pulses only on addr 1023.
  - The next byte lands at addr 0.
- Commands 0x21,0x10,0x11 then 0x22,0x02,0x03, then 5 data bytes:
  - wr_addr = 272, 273, 400, 401, 272.
  - frame_done pulses on the 4th byte.
  - 6 cmd_valid pulses.
- 0xAF then 0xAE: display_on goes 1 after the first cmd_valid, 0 after the second.
- 5 sclk bits, cs high, cs low, full byte 0xA5 with dc=1:
  - Exactly one wr_en, with wr_data=0xA5 at addr 0.
- 0x21,0x40 then a data byte 0x3C:
  - FSM aborts; write at addr 0 with 0x3C.
  - The next data byte goes to addr 1 (window unchanged).
- Pulse io_reset low for 10 cycles after writing 300 bytes with display_on=1:
  - display_on=0, no strobes during the pulse.
  - The next data byte writes addr 0.
